// File: rtl/muldiv_exec_unit.sv
// RV32M multiply/divide execute unit: 2-cycle multiplier and a 1-bit-per-cycle
// restoring divider, returning one tagged 32-bit result through valid/ready.
module muldiv_exec_unit (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        flush_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [2:0]  op_i,
  input  logic [31:0] num1_i,
  input  logic [31:0] num2_i,
  input  logic [4:0]  wb_reg_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic [4:0]  wb_reg_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  op_reg;
  logic [4:0]  tag_reg;
  logic [4:0]  cnt_reg;
  logic [32:0] a_reg, b_reg;
  logic [65:0] prod_reg;
  logic [31:0] q_reg;
  logic [32:0] rem_reg;
  logic [31:0] div_reg;
  logic        neg_q_reg, neg_r_reg;
  logic        valid_reg;
  logic [31:0] result_reg;

  logic        accept;
  logic        a_signed, b_signed, d_signed, n1_neg, n2_neg;
  logic [31:0] n1_abs, n2_abs;
  logic [65:0] prod_next;
  logic [32:0] shifted, trial, rem_step;
  logic        q_bit;
  logic [31:0] q_step, mul_res, div_res;

  assign accept   = valid_i && (state_reg == S_IDLE) && !flush_i;
  assign ready_o  = (state_reg == S_IDLE);
  assign valid_o  = valid_reg;
  assign result_o = result_reg;
  assign wb_reg_o = tag_reg;

  // Operand conditioning at accept time for both the multiplier and the divider
  assign a_signed = (op_i[1:0] != 2'b11);
  assign b_signed = !op_i[1];
  assign d_signed = !op_i[0];
  assign n1_neg   = d_signed && num1_i[31];
  assign n2_neg   = d_signed && num2_i[31];
  assign n1_abs   = n1_neg ? -num1_i : num1_i;
  assign n2_abs   = n2_neg ? -num2_i : num2_i;

  // Sign-extending to 66 bits makes the truncated unsigned product exact
  assign prod_next = {{33{a_reg[32]}}, a_reg} * {{33{b_reg[32]}}, b_reg};

  assign shifted  = {rem_reg[31:0], q_reg[31]};
  assign trial    = shifted - {1'b0, div_reg};
  assign q_bit    = !trial[32];
  assign rem_step = q_bit ? trial : shifted;
  assign q_step   = {q_reg[30:0], q_bit};

  assign mul_res = (op_reg[1:0] == 2'b00) ? prod_reg[31:0] : prod_reg[63:32];
  assign div_res = op_reg[1] ? rem_reg[31:0] : q_reg;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (!op_i[2])            state_next = S_MUL;
          else if (num2_i == '0)   state_next = S_DONE;
          else                     state_next = S_DIV;
        end
      end
      S_MUL:  state_next = S_DONE;
      S_DIV:  if (cnt_reg == 5'd31) state_next = S_DONE;
      S_DONE: if (valid_reg && ready_i) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush_i) state_next = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_reg     <= '0;
      tag_reg    <= '0;
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      prod_reg   <= '0;
      q_reg      <= '0;
      rem_reg    <= '0;
      div_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      valid_reg  <= 1'b0;
      result_reg <= '0;
    end else if (flush_i) begin
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            op_reg  <= op_i;
            tag_reg <= wb_reg_i;
            cnt_reg <= '0;
            a_reg   <= {a_signed && num1_i[31], num1_i};
            b_reg   <= {b_signed && num2_i[31], num2_i};
            div_reg <= n2_abs;
            if (num2_i == '0) begin
              // Divide by zero: all-ones quotient, untouched dividend as remainder
              q_reg     <= '1;
              rem_reg   <= {1'b0, num1_i};
              neg_q_reg <= 1'b0;
              neg_r_reg <= 1'b0;
            end else begin
              q_reg     <= n1_abs;
              rem_reg   <= '0;
              neg_q_reg <= n1_neg ^ n2_neg;
              neg_r_reg <= n1_neg;
            end
          end
        end
        S_MUL: prod_reg <= prod_next;
        S_DIV: begin
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd31) begin
            q_reg   <= neg_q_reg ? -q_step : q_step;
            rem_reg <= {1'b0, neg_r_reg ? -rem_step[31:0] : rem_step[31:0]};
          end else begin
            q_reg   <= q_step;
            rem_reg <= rem_step;
          end
        end
        S_DONE: begin
          // First DONE cycle captures the result; valid then holds until taken
          if (!valid_reg) begin
            valid_reg  <= 1'b1;
            result_reg <= op_reg[2] ? div_res : mul_res;
          end else if (ready_i) begin
            valid_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_exec_unit.sv
// Directed bench for muldiv_exec_unit: vector table plus backpressure, flush
// and asynchronous reset sequences.
module tb_muldiv_exec_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  op_i = '0;
  logic [31:0] num1_i = '0;
  logic [31:0] num2_i = '0;
  logic [4:0]  wb_reg_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] result_o;
  logic [4:0]  wb_reg_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  muldiv_exec_unit dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .flush_i  (flush_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .num1_i   (num1_i),
    .num2_i   (num2_i),
    .wb_reg_i (wb_reg_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .wb_reg_o (wb_reg_o)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] n1;
    logic [31:0] n2;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Offers one op at a negedge; returns the edge count until valid_o is seen
  task automatic issue(input logic [2:0] op, input logic [31:0] n1, input logic [31:0] n2,
                       input logic [4:0] tag, output int lat);
    @(negedge clk_i);
    valid_i = 1'b1; op_i = op; num1_i = n1; num2_i = n2; wb_reg_i = tag;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 100) begin
      @(posedge clk_i);
      lat++;
      @(negedge clk_i);
    end
  endtask

  initial begin
    int lat;
    logic [31:0] held_res;
    logic [4:0]  held_tag;
    int seen_valid;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 2};
    vecs[2]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2};
    vecs[3]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
    vecs[7]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};
    vecs[8]  = '{3'b101, 32'h00001234, 32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,        1};
    vecs[10] = '{3'b101, 32'd100,      32'd7,        32'd14,       33};
    vecs[11] = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
    vecs[12] = '{3'b111, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 33};
    vecs[13] = '{3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33};

    // Reset state
    #12;
    check("reset ready_o", {31'd0, ready_o}, 32'd1);
    check("reset valid_o", {31'd0, valid_o}, 32'd0);
    check("reset result_o", result_o, 32'd0);
    check("reset wb_reg_o", {27'd0, wb_reg_o}, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    for (int i = 0; i < 14; i++) begin
      ready_i = 1'b1;
      issue(vecs[i].op, vecs[i].n1, vecs[i].n2, 5'(i + 1), lat);
      $display("vec %0d op=%0d 0x%08h,0x%08h -> 0x%08h tag=%0d lat=%0d",
               i, vecs[i].op, vecs[i].n1, vecs[i].n2, result_o, wb_reg_o, lat);
      check($sformatf("vec%0d result", i), result_o, vecs[i].exp);
      check($sformatf("vec%0d tag", i), {27'd0, wb_reg_o}, 32'(i + 1));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d ready_o busy", i), {31'd0, ready_o}, 32'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      check($sformatf("vec%0d ready_o after handshake", i), {31'd0, ready_o}, 32'd1);
      check($sformatf("vec%0d valid_o after handshake", i), {31'd0, valid_o}, 32'd0);
    end

    // Backpressure: result held while ready_i low, offered op ignored
    ready_i = 1'b0;
    issue(3'b000, 32'd7, 32'hFFFFFFFD, 5'd9, lat);
    held_res = result_o;
    held_tag = wb_reg_o;
    check("bp result", held_res, 32'hFFFFFFEB);
    valid_i = 1'b1; op_i = 3'b011; num1_i = 32'd2; num2_i = 32'd3; wb_reg_i = 5'd20;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      check($sformatf("bp valid c%0d", c), {31'd0, valid_o}, 32'd1);
      check($sformatf("bp result c%0d", c), result_o, 32'hFFFFFFEB);
      check($sformatf("bp tag c%0d", c), {27'd0, wb_reg_o}, 32'd9);
      check($sformatf("bp ready_o c%0d", c), {31'd0, ready_o}, 32'd0);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    $display("backpressure release: ready_o=%0d valid_o=%0d", ready_o, valid_o);
    check("bp release ready_o", {31'd0, ready_o}, 32'd1);
    check("bp release valid_o", {31'd0, valid_o}, 32'd0);
    seen_valid = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      if (valid_o) seen_valid++;
    end
    check("bp offered op not accepted", 32'(seen_valid), 32'd0);

    // Flush at iteration 10 of a DIV
    @(negedge clk_i);
    valid_i = 1'b1; op_i = 3'b101; num1_i = 32'd1000; num2_i = 32'd3; wb_reg_i = 5'd11;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b0;
    $display("flush: ready_o=%0d valid_o=%0d", ready_o, valid_o);
    check("flush ready_o", {31'd0, ready_o}, 32'd1);
    seen_valid = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (valid_o) seen_valid++;
    end
    check("flush valid never", 32'(seen_valid), 32'd0);
    issue(3'b000, 32'd3, 32'd4, 5'd12, lat);
    $display("post-flush MUL 3x4 -> %0d tag=%0d lat=%0d", result_o, wb_reg_o, lat);
    check("post-flush mul result", result_o, 32'd12);
    check("post-flush mul latency", 32'(lat), 32'd2);
    @(posedge clk_i);

    // Asynchronous reset in the middle of a DIV
    @(negedge clk_i);
    valid_i = 1'b1; op_i = 3'b100; num1_i = 32'd50; num2_i = 32'd5; wb_reg_i = 5'd17;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    $display("async reset: ready_o=%0d valid_o=%0d result=0x%08h tag=%0d",
             ready_o, valid_o, result_o, wb_reg_o);
    check("rst ready_o", {31'd0, ready_o}, 32'd1);
    check("rst valid_o", {31'd0, valid_o}, 32'd0);
    check("rst result_o", result_o, 32'd0);
    check("rst wb_reg_o", {27'd0, wb_reg_o}, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    issue(3'b101, 32'd50, 32'd5, 5'd18, lat);
    $display("post-reset DIVU 50/5 -> %0d lat=%0d", result_o, lat);
    check("post-reset divu result", result_o, 32'd10);
    check("post-reset divu latency", 32'(lat), 32'd33);
    @(posedge clk_i);
    @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
